darkrom_arb: RTL



---
 rtl/darkrom_arb.sv | 92 +++++++++
 1 files changed

// File: rtl/darkrom_arb.sv
// Two-requester arbiter in front of the single-port instruction ROM: grants one
// access per cycle, tags the in-flight access and routes the response to its owner.
module darkrom_arb #(
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic             req0,
  input  logic             req1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [31:0]      rdata0,
  output logic [31:0]      rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             rom_en,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_data,
  input  logic             rom_valid,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       last;
  logic       tag_v;
  logic       tag;
  logic [3:0] starve;
  logic       pick1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  // Grant decision is combinational; reset holds every grant low.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pick1 = 1'b0;
    if (XRES) begin
      if (req0 && req1) begin
        if (PRIO_MODE == 0) pick1 = (last == 1'b0);
        else                pick1 = (starve == STARVE_LIM);
        gnt0 = ~pick1;
        gnt1 = pick1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign rom_en   = gnt0 | gnt1;
  assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : 32'd0);

  // Response stage: a ROM valid without a live tag is dropped silently.
  assign rvalid0 = tag_v & rom_valid & ~tag;
  assign rvalid1 = tag_v & rom_valid & tag;
  assign rdata0  = rom_data;
  assign rdata1  = rom_data;

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      last   <= 1'b1;
      tag_v  <= 1'b0;
      tag    <= 1'b0;
      starve <= 4'd0;
      gcnt0  <= '0;
      gcnt1  <= '0;
    end else begin
      tag_v <= rom_en;
      if (rom_en) begin
        tag  <= gnt1;
        last <= gnt1;
      end
      if (req1 && !gnt1) starve <= sat_inc4(starve);
      else               starve <= 4'd0;
      if (gnt0) gcnt0 <= sat_inc(gcnt0);
      if (gnt1) gcnt1 <= sat_inc(gcnt1);
    end
  end

endmodule
